// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: computes the HI/LO result when an operation is
// accepted, then holds it back for a fixed busy window before committing.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  md_op,
  input  logic        start,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        rd_sel,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rd_data
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      hi_pend, lo_pend;
  logic             pend_wr;

  logic        is_md, is_div, op_start, do_commit;
  logic [63:0] prod_s, prod_u;
  logic [31:0] a_mag, b_mag, q_mag, r_mag;
  logic [31:0] quot_s, rem_s, quot_u, rem_u;
  logic [31:0] res_hi, res_lo;
  logic        res_wr;

  assign is_md  = (md_op >= OP_MULT) && (md_op <= OP_DIVU);
  assign is_div = (md_op == OP_DIV) || (md_op == OP_DIVU);

  assign prod_s = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
  assign prod_u = {32'b0, rs_val} * {32'b0, rt_val};

  // Signed divide via magnitudes, so 0x80000000 / -1 wraps cleanly to 0x80000000.
  assign a_mag  = rs_val[31] ? (~rs_val + 32'd1) : rs_val;
  assign b_mag  = rt_val[31] ? (~rt_val + 32'd1) : rt_val;
  assign q_mag  = (b_mag == 32'd0) ? 32'd0 : a_mag / b_mag;
  assign r_mag  = (b_mag == 32'd0) ? 32'd0 : a_mag % b_mag;
  assign quot_s = (rs_val[31] ^ rt_val[31]) ? (~q_mag + 32'd1) : q_mag;
  assign rem_s  = rs_val[31] ? (~r_mag + 32'd1) : r_mag;
  assign quot_u = (rt_val == 32'd0) ? 32'd0 : rs_val / rt_val;
  assign rem_u  = (rt_val == 32'd0) ? 32'd0 : rs_val % rt_val;

  always_comb begin
    res_hi = '0;
    res_lo = '0;
    res_wr = 1'b1;
    case (md_op)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV: begin
        res_hi = rem_s;
        res_lo = quot_s;
        res_wr = (rt_val != 32'd0);
      end
      OP_DIVU: begin
        res_hi = rem_u;
        res_lo = quot_u;
        res_wr = (rt_val != 32'd0);
      end
      default: res_wr = 1'b0;
    endcase
  end

  always_comb begin
    state_next = state;
    op_start   = 1'b0;
    do_commit  = 1'b0;
    case (state)
      IDLE: begin
        if (start && is_md) begin
          op_start   = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (cnt == CNT_W'(1)) begin
          do_commit  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // A divide by zero still runs its full window but suppresses the commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi      <= '0;
      lo      <= '0;
      cnt     <= '0;
      hi_pend <= '0;
      lo_pend <= '0;
      pend_wr <= 1'b0;
    end else begin
      if (op_start) begin
        hi_pend <= res_hi;
        lo_pend <= res_lo;
        pend_wr <= res_wr;
        cnt     <= is_div ? DIV_LOAD : MULT_LOAD;
      end else if (state == RUN) begin
        cnt <= cnt - CNT_W'(1);
      end

      if (do_commit && pend_wr) begin
        hi <= hi_pend;
        lo <= lo_pend;
      end else if (state == IDLE && md_op == OP_MTHI) begin
        hi <= rs_val;
      end else if (state == IDLE && md_op == OP_MTLO) begin
        lo <= rs_val;
      end
    end
  end

  assign busy    = (state == RUN);
  assign rd_data = rd_sel ? hi : lo;

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: directed vectors, multi-cycle corner sequences
// and randomized traffic against a cycle-scheduled arithmetic reference model.
module tb_e_mdu;

  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  md_op;
  logic        start;
  logic [31:0] rs_val, rt_val;
  logic        rd_sel;
  logic        busy;
  logic [31:0] hi, lo, rd_data;

  int checks = 0;
  int errors = 0;

  // Reference model: architectural HI/LO plus one scheduled completion.
  logic [31:0] m_hi, m_lo;
  bit          m_pending;
  logic [2:0]  p_op;
  logic [31:0] p_a, p_b;
  int          cyc, done_cyc;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          lat;
  } vec_t;

  vec_t vecs[6];

  e_mdu #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
    .clk     (clk),
    .reset   (reset),
    .md_op   (md_op),
    .start   (start),
    .rs_val  (rs_val),
    .rt_val  (rt_val),
    .rd_sel  (rd_sel),
    .busy    (busy),
    .hi      (hi),
    .lo      (lo),
    .rd_data (rd_data)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [63:0] refCalc(input logic [2:0] op, input logic [31:0] a, b,
                                          input logic [31:0] cur_hi, cur_lo);
    longint sa, sb, ua, ub, p, q, r;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      3'd1: begin p = sa * sb; return p; end
      3'd2: begin p = ua * ub; return p; end
      3'd3: begin
        if (b == 32'd0) return {cur_hi, cur_lo};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      3'd4: begin
        if (b == 32'd0) return {cur_hi, cur_lo};
        q = ua / ub;
        r = ua % ub;
        return {r[31:0], q[31:0]};
      end
      default: return {cur_hi, cur_lo};
    endcase
  endfunction

  task automatic modelEdge();
    cyc++;
    if (reset) begin
      m_hi      = '0;
      m_lo      = '0;
      m_pending = 0;
    end else if (m_pending) begin
      if (cyc == done_cyc) begin
        {m_hi, m_lo} = refCalc(p_op, p_a, p_b, m_hi, m_lo);
        m_pending = 0;
      end
    end else if (start && md_op >= 3'd1 && md_op <= 3'd4) begin
      p_op      = md_op;
      p_a       = rs_val;
      p_b       = rt_val;
      m_pending = 1;
      done_cyc  = cyc + ((md_op >= 3'd3) ? DIV_CYCLES : MULT_CYCLES);
    end else if (md_op == 3'd5) begin
      m_hi = rs_val;
    end else if (md_op == 3'd6) begin
      m_lo = rs_val;
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic checkInt(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, clock the edge, advance the model, settle.
  task automatic applyStimulus(input logic [2:0] op, input logic st,
                               input logic [31:0] a, input logic [31:0] b);
    md_op  = op;
    start  = st;
    rs_val = a;
    rt_val = b;
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic checkOutput(input string name);
    checkInt({name, "_busy"}, int'(busy), int'(m_pending));
    check32({name, "_hi"}, hi, m_hi);
    check32({name, "_lo"}, lo, m_lo);
    rd_sel = 1'b1;
    #1;
    check32({name, "_rdhi"}, rd_data, m_hi);
    rd_sel = 1'b0;
    #1;
    check32({name, "_rdlo"}, rd_data, m_lo);
  endtask

  task automatic waitIdle(output int n);
    n = 0;
    while (busy && n < 40) begin
      applyStimulus(3'd0, 1'b0, $urandom, $urandom);
      checkOutput("run");
      n++;
    end
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    logic [2:0] op;
    logic st;

    vecs[0] = '{3'd1, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, MULT_CYCLES};
    vecs[1] = '{3'd2, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0002, 32'hFFFF_FFFA, MULT_CYCLES};
    vecs[2] = '{3'd3, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_CYCLES};
    vecs[3] = '{3'd4, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, DIV_CYCLES};
    vecs[4] = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, DIV_CYCLES};
    vecs[5] = '{3'd3, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, DIV_CYCLES};

    m_hi = '0; m_lo = '0; m_pending = 0; cyc = 0; done_cyc = 0;
    p_op = '0; p_a = '0; p_b = '0;
    reset = 1'b1; md_op = '0; start = 1'b0; rs_val = '0; rt_val = '0; rd_sel = 1'b0;

    $display("[TB] reset");
    applyStimulus(3'd0, 1'b0, 32'h0, 32'h0);
    applyStimulus(3'd0, 1'b0, 32'h0, 32'h0);
    reset = 1'b0;
    applyStimulus(3'd0, 1'b0, 32'h0, 32'h0);
    check32("reset_hi", hi, 32'h0);
    check32("reset_lo", lo, 32'h0);
    checkOutput("reset");

    $display("[TB] directed vectors");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].op, 1'b1, vecs[i].rs, vecs[i].rt);
      checkOutput("vec_start");
      waitIdle(n);
      checkInt($sformatf("vec%0d_lat", i), n, vecs[i].lat);
      check32($sformatf("vec%0d_hi", i), hi, vecs[i].exp_hi);
      check32($sformatf("vec%0d_lo", i), lo, vecs[i].exp_lo);
      checkOutput("vec_done");
    end

    $display("[TB] divide by zero keeps HI/LO");
    applyStimulus(3'd5, 1'b0, 32'h0000_1234, 32'h0);
    applyStimulus(3'd6, 1'b0, 32'h0000_5678, 32'h0);
    checkOutput("mt");
    applyStimulus(3'd3, 1'b1, 32'h0000_0055, 32'h0);
    waitIdle(n);
    checkInt("divz_lat", n, DIV_CYCLES);
    check32("divz_hi", hi, 32'h0000_1234);
    check32("divz_lo", lo, 32'h0000_5678);

    $display("[TB] reset during MULT");
    applyStimulus(3'd1, 1'b1, 32'd7, 32'd9);
    applyStimulus(3'd0, 1'b0, 32'h0, 32'h0);
    applyStimulus(3'd0, 1'b0, 32'h0, 32'h0);
    reset = 1'b1;
    applyStimulus(3'd0, 1'b0, 32'h0, 32'h0);
    reset = 1'b0;
    checkInt("abort_busy", int'(busy), 0);
    check32("abort_hi", hi, 32'h0);
    check32("abort_lo", lo, 32'h0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(3'd0, 1'b0, 32'h0, 32'h0);
      checkOutput("abort_after");
    end
    check32("abort_nocommit_lo", lo, 32'h0);

    $display("[TB] ignored during busy and back-to-back");
    applyStimulus(3'd1, 1'b1, 32'd3, 32'd4);
    applyStimulus(3'd6, 1'b0, 32'h0000_AAAA, 32'h0);
    checkOutput("mtlo_busy");
    applyStimulus(3'd3, 1'b1, 32'd100, 32'd7);
    waitIdle(n);
    checkInt("ign_lat", n + 2, MULT_CYCLES);
    check32("ign_lo", lo, 32'd12);
    check32("ign_hi", hi, 32'd0);
    applyStimulus(3'd1, 1'b1, 32'd5, 32'd6);
    check32("b2b_hold_lo", lo, 32'd12);
    checkInt("b2b_busy", int'(busy), 1);
    waitIdle(n);
    checkInt("b2b_lat", n, MULT_CYCLES);
    check32("b2b_lo", lo, 32'd30);
    check32("b2b_hi", hi, 32'd0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      op = 3'($urandom_range(0, 7));
      if (op >= 3'd1 && op <= 3'd4) st = ($urandom_range(0, 3) != 0);
      else                          st = 1'($urandom_range(0, 1));
      applyStimulus(op, st, pickOperand(), pickOperand());
      checkOutput("rand");
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
